// File: rtl/sp_ram_fc_pkg.sv
// Shared types and constants for the single-port RAM fill/check engine.
package sp_ram_fc_pkg;

    typedef enum logic [1:0] {
        MODE_FILL       = 2'd0,
        MODE_CHECK      = 2'd1,
        MODE_FILL_CHECK = 2'd2,
        MODE_RSVD       = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        PAT_CONST    = 2'd0,
        PAT_INCR     = 2'd1,
        PAT_ADDR     = 2'd2,
        PAT_INV_ADDR = 2'd3
    } pattern_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int ERR_CNT_W = 16;

    // Wide enough for any supported word width; sliced to DATA_WIDTH/8 at use.
    localparam logic [127:0] BE_ALL_ONES = '1;

endpackage

// File: rtl/sp_ram_pattern_gen.sv
// Combinational pattern word for a given index / word address; shared by the
// write data path and the read compare path so both always agree.
module sp_ram_pattern_gen
    import sp_ram_fc_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            pattern,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [ADDR_WIDTH-2:0] index,
    input  logic [ADDR_WIDTH-3:0] word_addr,
    output logic [DATA_WIDTH-1:0] data
);

    always_comb begin
        data = seed;
        case (pattern_e'(pattern))
            PAT_CONST:    data = seed;
            PAT_INCR:     data = seed + DATA_WIDTH'(index);
            PAT_ADDR:     data = DATA_WIDTH'(word_addr);
            PAT_INV_ADDR: data = ~DATA_WIDTH'(word_addr);
            default:      data = seed;
        endcase
    end

endmodule

// File: rtl/sp_ram_fill_check.sv
// Fill / read-back-check engine for the single-port data RAM request port.
// Define SP_RAM_CHECK_ERR_LOG_EN to add the first-mismatch log outputs.
//
// state | meaning
// IDLE  | port released, waiting for start_i
// WRITE | one pattern write per cycle
// READ  | one read per cycle, expected word registered for next-cycle compare
// DRAIN | no request, compares the last read word
// DONE  | one-cycle done_o pulse
module sp_ram_fill_check
    import sp_ram_fc_pkg::*;
#(
    parameter int RAM_SIZE   = 16384,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [1:0]              mode_i,
    input  logic [1:0]              pattern_i,
    input  logic [DATA_WIDTH-1:0]   seed_i,
    input  logic [ADDR_WIDTH-3:0]   base_i,
    input  logic [ADDR_WIDTH-2:0]   count_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [15:0]             err_cnt_o,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
`ifdef SP_RAM_CHECK_ERR_LOG_EN
    ,
    output logic [ADDR_WIDTH-3:0]   err_addr_o,
    output logic [DATA_WIDTH-1:0]   err_exp_o,
    output logic [DATA_WIDTH-1:0]   err_got_o
`endif
);

    localparam int WA_W = ADDR_WIDTH - 2;
    localparam int CNT_W = ADDR_WIDTH - 1;
    localparam int BE_W = DATA_WIDTH / 8;
    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(RAM_SIZE / 4);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_WRITE = ST_WRITE;
    localparam logic [2:0] S_READ  = ST_READ;
    localparam logic [2:0] S_DRAIN = ST_DRAIN;
    localparam logic [2:0] S_DONE  = ST_DONE;

    logic [2:0]            state_q;
    logic [1:0]            mode_q;
    logic [1:0]            pat_q;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [WA_W-1:0]       base_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      idx_q;
    logic                  cmp_vld_q;
    logic [DATA_WIDTH-1:0] cmp_exp_q;
    logic                  err_q;
    logic [ERR_CNT_W-1:0]  err_cnt_q;
`ifdef SP_RAM_CHECK_ERR_LOG_EN
    logic [WA_W-1:0]       cmp_addr_q;
`endif

    logic [WA_W-1:0]       word_addr;
    logic [DATA_WIDTH-1:0] pat_data;
    logic [CNT_W-1:0]      start_cnt;
    logic                  last_word;
    logic                  mismatch;

    // Word address wraps modulo the RAM word count by truncation.
    assign word_addr = base_q + idx_q[WA_W-1:0];
    assign last_word = (idx_q == cnt_q - CNT_W'(1));
    assign mismatch  = cmp_vld_q && (ram_rdata_i != cmp_exp_q);
    assign start_cnt = (count_i > MAX_WORDS) ? MAX_WORDS : count_i;

    sp_ram_pattern_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pattern_gen (
        .pattern   (pat_q),
        .seed      (seed_q),
        .index     (idx_q),
        .word_addr (word_addr),
        .data      (pat_data)
    );

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            pat_q     <= '0;
            seed_q    <= '0;
            base_q    <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            cmp_vld_q <= 1'b0;
            cmp_exp_q <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
`ifdef SP_RAM_CHECK_ERR_LOG_EN
            cmp_addr_q <= '0;
            err_addr_o <= '0;
            err_exp_o  <= '0;
            err_got_o  <= '0;
`endif
        end else begin
            cmp_vld_q <= (state_q == S_READ);
            if (state_q == S_READ) begin
                cmp_exp_q <= pat_data;
`ifdef SP_RAM_CHECK_ERR_LOG_EN
                cmp_addr_q <= word_addr;
`endif
            end

            if (mismatch) begin
                err_q <= 1'b1;
                if (err_cnt_q != '1) begin
                    err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                end
`ifdef SP_RAM_CHECK_ERR_LOG_EN
                if (!err_q) begin
                    err_addr_o <= cmp_addr_q;
                    err_exp_o  <= cmp_exp_q;
                    err_got_o  <= ram_rdata_i;
                end
`endif
            end

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mode_q    <= mode_i;
                        pat_q     <= pattern_i;
                        seed_q    <= seed_i;
                        base_q    <= base_i;
                        cnt_q     <= start_cnt;
                        idx_q     <= '0;
                        err_q     <= 1'b0;
                        err_cnt_q <= '0;
`ifdef SP_RAM_CHECK_ERR_LOG_EN
                        err_addr_o <= '0;
                        err_exp_o  <= '0;
                        err_got_o  <= '0;
`endif
                        if (start_cnt == '0 || mode_i == MODE_RSVD) begin
                            state_q <= S_DONE;
                        end else if (mode_i == MODE_CHECK) begin
                            state_q <= S_READ;
                        end else begin
                            state_q <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (last_word) begin
                        if (mode_q == MODE_FILL_CHECK) begin
                            idx_q   <= '0;
                            state_q <= S_READ;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end else begin
                        idx_q <= idx_q + CNT_W'(1);
                    end
                end
                S_READ: begin
                    if (last_word) begin
                        state_q <= S_DRAIN;
                    end else begin
                        idx_q <= idx_q + CNT_W'(1);
                    end
                end
                S_DRAIN: state_q <= S_DONE;
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
        err_o       = err_q;
        err_cnt_o   = err_cnt_q;
        ram_en_o    = (state_q == S_WRITE) || (state_q == S_READ);
        ram_we_o    = (state_q == S_WRITE);
        ram_addr_o  = '0;
        ram_be_o    = '0;
        ram_wdata_o = '0;
        if (ram_en_o) begin
            ram_addr_o = {word_addr, 2'b00};
            ram_be_o   = BE_ALL_ONES[BE_W-1:0];
        end
        if (ram_we_o) begin
            ram_wdata_o = pat_data;
        end
    end

endmodule

// File: tb/tb_sp_ram_fill_check.sv
// Randomized + directed bench for sp_ram_fill_check with a RAM model and a
// word-level reference model; log ports checked when SP_RAM_CHECK_ERR_LOG_EN is set.
module tb_sp_ram_fill_check;

    localparam int AW    = 14;
    localparam int DW    = 32;
    localparam int WORDS = 4096;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [1:0]    mode_i = '0;
    logic [1:0]    pattern_i = '0;
    logic [DW-1:0] seed_i = '0;
    logic [AW-3:0] base_i = '0;
    logic [AW-2:0] count_i = '0;
    logic          busy_o, done_o, err_o;
    logic [15:0]   err_cnt_o;
    logic          ram_en_o, ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [3:0]    ram_be_o;
    logic [DW-1:0] ram_wdata_o;
    logic [DW-1:0] ram_rdata_i = '0;
`ifdef SP_RAM_CHECK_ERR_LOG_EN
    logic [AW-3:0] err_addr_o;
    logic [DW-1:0] err_exp_o, err_got_o;
`endif

    sp_ram_fill_check dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .mode_i      (mode_i),
        .pattern_i   (pattern_i),
        .seed_i      (seed_i),
        .base_i      (base_i),
        .count_i     (count_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .err_cnt_o   (err_cnt_o),
        .ram_en_o    (ram_en_o),
        .ram_addr_o  (ram_addr_o),
        .ram_we_o    (ram_we_o),
        .ram_be_o    (ram_be_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
`ifdef SP_RAM_CHECK_ERR_LOG_EN
        ,
        .err_addr_o  (err_addr_o),
        .err_exp_o   (err_exp_o),
        .err_got_o   (err_got_o)
`endif
    );

    always #5 clk = ~clk;

    // RAM model: registered read, plus a back-door poke used between commands
    logic          poke_en = 1'b0;
    logic [11:0]   poke_addr = '0;
    logic [DW-1:0] poke_data = '0;
    logic [DW-1:0] mem [WORDS] = '{default: 32'h0};

    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (ram_en_o) begin
            if (ram_we_o) mem[ram_addr_o[AW-1:2]] <= ram_wdata_o;
            else          ram_rdata_i <= mem[ram_addr_o[AW-1:2]];
        end
    end

    // Reference model state
    logic [DW-1:0] shadow [WORDS];
    int            cmd_mode, cmd_pat, cmd_base, cmd_n;
    logic [DW-1:0] cmd_seed;
    int            exp_wr_n, exp_rd_n, exp_done_cyc, exp_errs, rd_start;
    logic          exp_err;
    logic [15:0]   exp_err_cnt;
    int            exp_log_addr;
    logic [DW-1:0] exp_log_exp, exp_log_got;

    // Observations of one command
    int            obs_wr_n, obs_rd_n, obs_wr_bad, obs_rd_bad, obs_proto_bad, obs_done_cyc;
    logic [AW-1:0] obs_wr0_addr;
    logic [DW-1:0] obs_wr0_data;
    logic          obs_err;
    logic [15:0]   obs_err_cnt;
    int            obs_log_addr;
    logic [DW-1:0] obs_log_exp, obs_log_got;

    int n_pass = 0;
    int n_total = 0;

    function automatic int ref_wa(int k);
        return (cmd_base + k) % WORDS;
    endfunction

    function automatic logic [DW-1:0] ref_pat(int k);
        case (cmd_pat)
            0:       return cmd_seed;
            1:       return cmd_seed + 32'(k);
            2:       return 32'(ref_wa(k));
            default: return ~32'(ref_wa(k));
        endcase
    endfunction

    task automatic model_run(int mode, int pat, logic [DW-1:0] seed, int base, int count);
        cmd_mode = mode; cmd_pat = pat; cmd_seed = seed; cmd_base = base;
        cmd_n = (count > WORDS) ? WORDS : count;
        exp_wr_n = 0; exp_rd_n = 0; exp_done_cyc = 1; rd_start = 1;
        if (cmd_n > 0 && mode != 3) begin
            if (mode == 0) begin exp_wr_n = cmd_n; exp_done_cyc = cmd_n + 1; end
            if (mode == 1) begin exp_rd_n = cmd_n; exp_done_cyc = cmd_n + 2; end
            if (mode == 2) begin
                exp_wr_n = cmd_n; exp_rd_n = cmd_n;
                exp_done_cyc = 2 * cmd_n + 2; rd_start = cmd_n + 1;
            end
        end
        for (int k = 0; k < exp_wr_n; k++) shadow[ref_wa(k)] = ref_pat(k);
        exp_errs = 0;
        exp_log_addr = 0; exp_log_exp = '0; exp_log_got = '0;
        for (int k = 0; k < exp_rd_n; k++) begin
            if (shadow[ref_wa(k)] != ref_pat(k)) begin
                if (exp_errs == 0) begin
                    exp_log_addr = ref_wa(k);
                    exp_log_exp  = ref_pat(k);
                    exp_log_got  = shadow[ref_wa(k)];
                end
                exp_errs++;
            end
        end
        exp_err = (exp_errs > 0);
        exp_err_cnt = (exp_errs > 16'hFFFF) ? 16'hFFFF : 16'(exp_errs);
    endtask

    task automatic poke(int wa, logic [DW-1:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = 12'(wa); poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
        shadow[wa] = d;
    endtask

    // Issues one command and records what the DUT does, cycle by cycle,
    // relative to the start-accept edge (cycle 0 = the start_i cycle).
    task automatic run_cmd(int mode, int pat, logic [DW-1:0] seed, int base, int count, int repulse_cyc);
        int  budget, k;
        bit  done_seen;
        model_run(mode, pat, seed, base, count);
        @(negedge clk);
        start_i = 1'b1; mode_i = 2'(mode); pattern_i = 2'(pat);
        seed_i = seed; base_i = 12'(base); count_i = 13'(count);
        @(negedge clk);
        start_i = 1'b0;
        mode_i = 2'($urandom); pattern_i = 2'($urandom); seed_i = $urandom;
        base_i = 12'($urandom); count_i = 13'($urandom);
        obs_wr_n = 0; obs_rd_n = 0; obs_wr_bad = 0; obs_rd_bad = 0; obs_proto_bad = 0;
        obs_done_cyc = -1; obs_wr0_addr = '1; obs_wr0_data = '1;
        obs_err = 1'bx; obs_err_cnt = 'x;
        obs_log_addr = -1; obs_log_exp = 'x; obs_log_got = 'x;
        done_seen = 0;
        budget = exp_done_cyc + 8;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (done_seen) begin
                if (busy_o !== 1'b0 || done_o !== 1'b0 || ram_en_o !== 1'b0) obs_proto_bad++;
                break;
            end
            if (busy_o !== 1'b1) obs_proto_bad++;
            if (ram_en_o === 1'b1) begin
                if (ram_addr_o[1:0] !== 2'b00 || ram_be_o !== 4'hF) obs_proto_bad++;
                if (ram_we_o === 1'b1) begin
                    k = obs_wr_n;
                    if (k == 0) begin obs_wr0_addr = ram_addr_o; obs_wr0_data = ram_wdata_o; end
                    if (k >= exp_wr_n || cyc != 1 + k || ram_addr_o !== 14'(ref_wa(k) * 4)
                        || ram_wdata_o !== ref_pat(k)) obs_wr_bad++;
                    obs_wr_n++;
                end else begin
                    k = obs_rd_n;
                    if (k >= exp_rd_n || cyc != rd_start + k || ram_addr_o !== 14'(ref_wa(k) * 4))
                        obs_rd_bad++;
                    obs_rd_n++;
                end
            end
            if (done_o === 1'b1) begin
                done_seen = 1;
                obs_done_cyc = cyc;
                obs_err = err_o;
                obs_err_cnt = err_cnt_o;
`ifdef SP_RAM_CHECK_ERR_LOG_EN
                obs_log_addr = int'(err_addr_o);
                obs_log_exp = err_exp_o;
                obs_log_got = err_got_o;
`endif
            end
            start_i = (cyc == repulse_cyc);
            if (cyc == repulse_cyc) begin mode_i = 2'd1; count_i = 13'd5; end
            @(negedge clk);
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({busy_o, done_o, err_o, ram_en_o, ram_we_o, err_cnt_o, ram_addr_o, ram_be_o, ram_wdata_o} !== '0)
            $display("FAIL reset_outputs: busy=%b done=%b err=%b en=%b we=%b cnt=%h addr=%h be=%h wdata=%h, want all 0",
                     busy_o, done_o, err_o, ram_en_o, ram_we_o, err_cnt_o, ram_addr_o, ram_be_o, ram_wdata_o);
        else n_pass++;
`ifdef SP_RAM_CHECK_ERR_LOG_EN
        n_total++;
        if ({err_addr_o, err_exp_o, err_got_o} !== '0)
            $display("FAIL reset_log: addr=%h exp=%h got=%h, want 0", err_addr_o, err_exp_o, err_got_o);
        else n_pass++;
`endif
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill_incr();
        run_cmd(0, 1, 32'h1000, 'h10, 4, 0);
        n_total++;
        if (obs_wr_n !== 4) $display("FAIL fill_wr_count: got %0d want 4", obs_wr_n); else n_pass++;
        n_total++;
        if (obs_wr0_addr !== 14'h40 || obs_wr0_data !== 32'h1000)
            $display("FAIL fill_first_write: got addr=%h data=%h want 0040/00001000", obs_wr0_addr, obs_wr0_data);
        else n_pass++;
        n_total++;
        if (obs_wr_bad !== 0 || obs_rd_n !== 0) $display("FAIL fill_writes: bad=%0d reads=%0d want 0/0", obs_wr_bad, obs_rd_n);
        else n_pass++;
        n_total++;
        if (obs_done_cyc !== 5) $display("FAIL fill_done_cycle: got %0d want 5", obs_done_cyc); else n_pass++;
        n_total++;
        if (obs_err !== 1'b0 || obs_proto_bad !== 0)
            $display("FAIL fill_err_proto: err=%b proto_bad=%0d want 0/0", obs_err, obs_proto_bad);
        else n_pass++;
    endtask

    task automatic test_fill_check_wrap();
        run_cmd(2, 2, 32'h0, 'hFFE, 4, 0);
        n_total++;
        if (obs_wr0_addr !== 14'h3FF8) $display("FAIL wrap_first_addr: got %h want 3ff8", obs_wr0_addr); else n_pass++;
        n_total++;
        if (obs_wr_n !== 4 || obs_rd_n !== 4 || obs_wr_bad !== 0 || obs_rd_bad !== 0)
            $display("FAIL wrap_traffic: wr=%0d rd=%0d wr_bad=%0d rd_bad=%0d want 4/4/0/0",
                     obs_wr_n, obs_rd_n, obs_wr_bad, obs_rd_bad);
        else n_pass++;
        n_total++;
        if (obs_done_cyc !== 10) $display("FAIL wrap_done_cycle: got %0d want 10", obs_done_cyc); else n_pass++;
        n_total++;
        if (obs_err !== 1'b0 || obs_err_cnt !== 16'h0)
            $display("FAIL wrap_err: err=%b cnt=%0d want 0/0", obs_err, obs_err_cnt);
        else n_pass++;
    endtask

    task automatic test_check_corrupt();
        run_cmd(0, 0, 32'hA5A5A5A5, 0, 8, 0);
        poke(3, 32'hA5A5A5A4);
        run_cmd(1, 0, 32'hA5A5A5A5, 0, 8, 0);
        n_total++;
        if (obs_err !== 1'b1 || obs_err_cnt !== 16'd1)
            $display("FAIL corrupt_err: err=%b cnt=%0d want 1/1", obs_err, obs_err_cnt);
        else n_pass++;
        n_total++;
        if (obs_done_cyc !== 10 || obs_rd_n !== 8 || obs_rd_bad !== 0)
            $display("FAIL corrupt_reads: done=%0d rd=%0d rd_bad=%0d want 10/8/0", obs_done_cyc, obs_rd_n, obs_rd_bad);
        else n_pass++;
`ifdef SP_RAM_CHECK_ERR_LOG_EN
        n_total++;
        if (obs_log_addr !== 3 || obs_log_exp !== 32'hA5A5A5A5 || obs_log_got !== 32'hA5A5A5A4)
            $display("FAIL corrupt_log: addr=%0d exp=%h got=%h want 3/a5a5a5a5/a5a5a5a4",
                     obs_log_addr, obs_log_exp, obs_log_got);
        else n_pass++;
`endif
    endtask

    task automatic test_zero_and_reserved();
        run_cmd(0, 1, 32'h55, 7, 0, 0);
        n_total++;
        if (obs_done_cyc !== 1 || obs_wr_n + obs_rd_n !== 0)
            $display("FAIL zero_count: done=%0d accesses=%0d want 1/0", obs_done_cyc, obs_wr_n + obs_rd_n);
        else n_pass++;
        run_cmd(3, 0, 32'h55, 7, 5, 0);
        n_total++;
        if (obs_done_cyc !== 1 || obs_wr_n + obs_rd_n !== 0 || obs_proto_bad !== 0)
            $display("FAIL reserved_mode: done=%0d accesses=%0d proto_bad=%0d want 1/0/0",
                     obs_done_cyc, obs_wr_n + obs_rd_n, obs_proto_bad);
        else n_pass++;
    endtask

    task automatic test_clamp_repulse();
        run_cmd(0, 0, $urandom, 0, 'h1FFF, 10);
        n_total++;
        if (obs_wr_n !== 4096 || obs_wr_bad !== 0 || obs_rd_n !== 0)
            $display("FAIL clamp_writes: wr=%0d bad=%0d rd=%0d want 4096/0/0", obs_wr_n, obs_wr_bad, obs_rd_n);
        else n_pass++;
        n_total++;
        if (obs_done_cyc !== 4097) $display("FAIL clamp_done_cycle: got %0d want 4097", obs_done_cyc); else n_pass++;
    endtask

    task automatic test_mid_reset();
        logic [DW-1:0] seed;
        int dones;
        seed = $urandom;
        run_cmd(0, 1, seed, 'h100, 10, 0);
        poke('h102, ~shadow['h102]);
        @(negedge clk);
        start_i = 1'b1; mode_i = 2'd1; pattern_i = 2'd1; seed_i = seed; base_i = 12'h100; count_i = 13'd10;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        n_total++;
        if (ram_en_o !== 1'b1 || ram_we_o !== 1'b0 || ram_addr_o !== 14'(('h105) * 4) || err_cnt_o !== 16'd1)
            $display("FAIL midrst_before: en=%b we=%b addr=%h cnt=%0d want 1/0/0414/1",
                     ram_en_o, ram_we_o, ram_addr_o, err_cnt_o);
        else n_pass++;
        rst_i = 1'b1;
        @(negedge clk);
        n_total++;
        if (ram_en_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0 || err_cnt_o !== 16'd0)
            $display("FAIL midrst_after: en=%b busy=%b err=%b cnt=%0d want 0/0/0/0",
                     ram_en_o, busy_o, err_o, err_cnt_o);
        else n_pass++;
        rst_i = 1'b0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            if (done_o === 1'b1 || err_o === 1'b1) dones++;
            @(negedge clk);
        end
        n_total++;
        if (dones !== 0) $display("FAIL midrst_quiet: done/err cycles=%0d want 0", dones); else n_pass++;
        run_cmd(1, 1, seed, 'h100, 10, 0);
        n_total++;
        if (obs_done_cyc !== 12 || obs_err !== 1'b1 || obs_err_cnt !== 16'd1)
            $display("FAIL midrst_rerun: done=%0d err=%b cnt=%0d want 12/1/1", obs_done_cyc, obs_err, obs_err_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        int mode, pat, base, count, npoke;
        for (int it = 0; it < 30; it++) begin
            mode  = $urandom_range(0, 3);
            pat   = $urandom_range(0, 3);
            base  = $urandom_range(0, WORDS - 1);
            count = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
            if (mode == 1) begin
                npoke = $urandom_range(0, 3);
                for (int p = 0; p < npoke; p++)
                    poke((base + $urandom_range(0, 40)) % WORDS, $urandom);
            end
            run_cmd(mode, pat, $urandom, base, count, (count > 4) ? 3 : 0);
            n_total++;
            if (obs_wr_n !== exp_wr_n || obs_wr_bad !== 0)
                $display("FAIL rand%0d_writes: wr=%0d bad=%0d want %0d/0", it, obs_wr_n, obs_wr_bad, exp_wr_n);
            else n_pass++;
            n_total++;
            if (obs_rd_n !== exp_rd_n || obs_rd_bad !== 0)
                $display("FAIL rand%0d_reads: rd=%0d bad=%0d want %0d/0", it, obs_rd_n, obs_rd_bad, exp_rd_n);
            else n_pass++;
            n_total++;
            if (obs_done_cyc !== exp_done_cyc || obs_proto_bad !== 0)
                $display("FAIL rand%0d_done: done=%0d proto_bad=%0d want %0d/0", it, obs_done_cyc, obs_proto_bad, exp_done_cyc);
            else n_pass++;
            n_total++;
            if (obs_err !== exp_err || obs_err_cnt !== exp_err_cnt)
                $display("FAIL rand%0d_err: err=%b cnt=%0d want %b/%0d", it, obs_err, obs_err_cnt, exp_err, exp_err_cnt);
            else n_pass++;
`ifdef SP_RAM_CHECK_ERR_LOG_EN
            n_total++;
            if (obs_log_addr !== exp_log_addr || obs_log_exp !== exp_log_exp || obs_log_got !== exp_log_got)
                $display("FAIL rand%0d_log: addr=%0d exp=%h got=%h want %0d/%h/%h", it,
                         obs_log_addr, obs_log_exp, obs_log_got, exp_log_addr, exp_log_exp, exp_log_got);
            else n_pass++;
`endif
        end
    endtask

    initial begin
        for (int w = 0; w < WORDS; w++) shadow[w] = '0;
        test_reset();
        test_fill_incr();
        test_fill_check_wrap();
        test_check_corrupt();
        test_zero_and_reserved();
        test_clamp_repulse();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
